// File: rtl/prog_exer2_2_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// prog_exer2_2_sweep_ctrl
// Exhaustively sweeps the 16 input vectors of an external 4-input function
// evaluator, captures its F output per vector into a truth table and compares
// the captured table against a golden table latched at sweep start.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : sweep request, only honoured in IDLE
//   abort        : cancels a sweep in progress (SETTLE/SAMPLE only)
//   expected     : golden truth table, bit i = required F for x=i
//   f_in         : F output of the evaluator for the vector on x_out
//   x_out        : vector currently driven to the evaluator
//   busy         : high while the sweep is in SETTLE or SAMPLE
//   done         : one-cycle pulse after a completed sweep
//   aborted      : one-cycle pulse after an accepted abort
//   table_out    : captured truth table
//   mismatch_cnt : number of captured bits differing from the golden table
//   first_bad    : lowest mismatching x (meaningful when mismatch_cnt != 0)
//   mismatch     : mismatch_cnt != 0
// -----------------------------------------------------------------------------
module prog_exer2_2_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  x_out,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_bad,
  output logic        mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);
  // With no settle time a vector goes straight to its sample cycle.
  localparam state_e FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e      state_q, state_d;
  logic [3:0]  x_q, x_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  fb_q, fb_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= 4'd0;
      wait_q    <= 4'd0;
      exp_q     <= 16'd0;
      tbl_q     <= 16'd0;
      cnt_q     <= 5'd0;
      fb_q      <= 4'd0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      wait_q    <= wait_d;
      exp_q     <= exp_d;
      tbl_q     <= tbl_d;
      cnt_q     <= cnt_d;
      fb_q      <= fb_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    wait_d    = wait_q;
    exp_d     = exp_q;
    tbl_d     = tbl_q;
    cnt_d     = cnt_q;
    fb_d      = fb_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort has no effect here, so start always wins.
        if (start) begin
          exp_d   = expected;
          tbl_d   = 16'd0;
          cnt_d   = 5'd0;
          fb_d    = 4'd0;
          x_d     = 4'd0;
          wait_d  = SETTLE_W;
          state_d = FIRST_ST;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (wait_q <= 4'd1) begin
          // Counter reaches zero this cycle: settle time has elapsed.
          wait_d  = 4'd0;
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // Abort wins over the sample of the current vector.
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          tbl_d[x_q] = f_in;
          if (f_in != exp_q[x_q]) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd0) begin
              fb_d = x_q;
            end else begin
              fb_d = fb_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
          if (x_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            x_d     = x_q + 4'd1;
            wait_d  = SETTLE_W;
            state_d = FIRST_ST;
          end
        end
      end

      ST_DONE: begin
        // done is registered, so the pulse appears on the cycle after DONE.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign x_out        = x_q;
  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign table_out    = tbl_q;
  assign mismatch_cnt = cnt_q;
  assign first_bad    = fb_q;
  assign mismatch     = (cnt_q != 5'd0);

endmodule

// File: tb/tb_prog_exer2_2_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for prog_exer2_2_sweep_ctrl. Two instances: index 0 with SETTLE=0,
// index 1 with SETTLE=1. Stimulus pushes the expected sweep outcome into a
// scoreboard queue; a monitor pops and compares on every done/aborted pulse.
// -----------------------------------------------------------------------------
module tb_prog_exer2_2_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s   [2];
  logic        abort_s   [2];
  logic [15:0] exp_s     [2];
  logic        f_s       [2];
  logic [3:0]  x_s       [2];
  logic        busy_s    [2];
  logic        done_s    [2];
  logic        ab_s      [2];
  logic [15:0] tbl_s     [2];
  logic [4:0]  cnt_s     [2];
  logic [3:0]  fb_s      [2];
  logic        mm_s      [2];
  logic [15:0] ftab      [2];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_pops = 0;

  typedef struct {
    int          inst;
    bit          is_abort;
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic [3:0]  fb;
    logic [3:0]  x;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The external evaluator is modelled as a lookup table set per sweep.
  assign f_s[0] = ftab[0][x_s[0]];
  assign f_s[1] = ftab[1][x_s[1]];

  prog_exer2_2_sweep_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .expected(exp_s[0]), .f_in(f_s[0]), .x_out(x_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .aborted(ab_s[0]), .table_out(tbl_s[0]),
    .mismatch_cnt(cnt_s[0]), .first_bad(fb_s[0]), .mismatch(mm_s[0])
  );

  prog_exer2_2_sweep_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .expected(exp_s[1]), .f_in(f_s[1]), .x_out(x_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .aborted(ab_s[1]), .table_out(tbl_s[1]),
    .mismatch_cnt(cnt_s[1]), .first_bad(fb_s[1]), .mismatch(mm_s[1])
  );

  // F = x3'x2 + x1x0 + x3x2' + x3x1'x0' tabulated over all 16 vectors.
  function automatic logic [15:0] ref_tab();
    logic [15:0] t;
    logic [3:0]  v;
    t = 16'd0;
    for (int x = 0; x < 16; x++) begin
      v = 4'(x);
      t[x] = (!v[3] && v[2]) || (v[1] && v[0]) || (v[3] && !v[2]) ||
             (v[3] && !v[1] && !v[0]);
    end
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_zero(input int i);
    chk("rst_x_out", 32'(x_s[i]), 32'd0);
    chk("rst_busy", 32'(busy_s[i]), 32'd0);
    chk("rst_done", 32'(done_s[i]), 32'd0);
    chk("rst_aborted", 32'(ab_s[i]), 32'd0);
    chk("rst_table", 32'(tbl_s[i]), 32'd0);
    chk("rst_cnt", 32'(cnt_s[i]), 32'd0);
    chk("rst_first_bad", 32'(fb_s[i]), 32'd0);
    chk("rst_mismatch", 32'(mm_s[i]), 32'd0);
  endtask

  // Pops one expectation per done/aborted pulse and compares the results.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst_n && (done_s[i] || ab_s[i])) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: inst %0d done=%0b aborted=%0b, want no pulse",
                     i, done_s[i], ab_s[i]);
          end else begin
            mon_e = sb.pop_front();
            n_pops++;
            chk("inst", 32'(i), 32'(mon_e.inst));
            chk("done", 32'(done_s[i]), 32'(!mon_e.is_abort));
            chk("aborted", 32'(ab_s[i]), 32'(mon_e.is_abort));
            chk("table_out", 32'(tbl_s[i]), 32'(mon_e.tbl));
            chk("mismatch_cnt", 32'(cnt_s[i]), 32'(mon_e.cnt));
            chk("first_bad", 32'(fb_s[i]), 32'(mon_e.fb));
            chk("mismatch", 32'(mm_s[i]), 32'(mon_e.cnt != 5'd0));
            chk("x_out", 32'(x_s[i]), 32'(mon_e.x));
            chk("busy_low", 32'(busy_s[i]), 32'd0);
            if (!mon_e.is_abort) chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          end
        end
      end
    end
  endtask

  // mode: 0 reference evaluator, 1 f_in tied 0, 2 random table.
  // abort_at/rst_at/mid_at < 0 disable the respective event.
  task automatic do_sweep(input int i, input logic [15:0] ex, input int mode,
                          input int abort_at, input int rst_at, input int mid_at,
                          input bit with_abort, input bit now, output bit did_rst);
    logic [15:0] ft;
    int          nw;
    int          target;
    bit          fired;
    exp_t        e;
    did_rst = 1'b0;
    target  = n_pops;
    if (mode == 0) ft = ref_tab();
    else if (mode == 1) ft = 16'h0000;
    else ft = 16'($urandom);
    if (!now) @(negedge clk);
    ftab[i]  = ft;
    exp_s[i] = ex;
    start_s[i] = 1'b1;
    abort_s[i] = with_abort;
    @(negedge clk);
    start_s[i] = 1'b0;
    abort_s[i] = 1'b0;
    nw = (abort_at < 0) ? 16 : abort_at;
    e.inst = i;
    e.is_abort = (abort_at >= 0);
    e.tbl = 16'd0;
    e.cnt = 5'd0;
    e.fb  = 4'd0;
    for (int x = 0; x < nw; x++) begin
      e.tbl[x] = ft[x];
      if (ft[x] != ex[x]) begin
        if (e.cnt == 5'd0) e.fb = 4'(x);
        e.cnt = e.cnt + 5'd1;
      end
    end
    e.x   = (abort_at < 0) ? 4'd15 : 4'(abort_at);
    e.acc = cyc;
    e.lat = 16 * (i + 1) + 1;
    if (rst_at < 0) begin
      sb.push_back(e);
      target = n_pops + 1;
    end
    fired = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (rst_at < 0 && n_pops >= target) break;
      start_s[i] = (mid_at >= 0) && (x_s[i] == 4'(mid_at));
      if (!fired && abort_at >= 0 && x_s[i] == 4'(abort_at)) begin
        abort_s[i] = 1'b1;
        fired = 1'b1;
      end else begin
        abort_s[i] = 1'b0;
      end
      if (rst_at >= 0 && x_s[i] == 4'(rst_at)) begin
        start_s[i] = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero(i);
        #1 rst_n = 1'b1;
        did_rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    start_s[i] = 1'b0;
    abort_s[i] = 1'b0;
    if (rst_at < 0 && n_pops < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: inst %0d no done/aborted pulse within 400 cycles", i);
    end
  endtask

  initial begin
    bit   r;
    int   ii;
    int   ab;
    int   md;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      exp_s[i]   = 16'd0;
      ftab[i]    = 16'd0;
    end
    fork
      monitor();
    join_none
    #3;
    chk_zero(0);
    chk_zero(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort alone in IDLE must not produce a pulse.
    abort_s[1] = 1'b1;
    @(negedge clk);
    abort_s[1] = 1'b0;

    do_sweep(1, 16'h9FF8, 0, -1, -1, -1, 1'b0, 1'b0, r);
    do_sweep(1, 16'h9FF0, 0, -1, -1, -1, 1'b0, 1'b0, r);
    do_sweep(0, 16'hFFFF, 1, -1, -1, -1, 1'b0, 1'b0, r);
    do_sweep(1, 16'h9FF8, 0, 5, -1, 2, 1'b0, 1'b0, r);
    do_sweep(0, 16'h1234, 0, 5, -1, 2, 1'b0, 1'b0, r);
    do_sweep(1, 16'h0F0F, 0, -1, -1, -1, 1'b1, 1'b0, r);
    do_sweep(1, 16'($urandom), 2, -1, 9, -1, 1'b0, 1'b0, r);
    if (r) do_sweep(1, 16'h9FF8, 0, -1, -1, -1, 1'b0, 1'b1, r);
    do_sweep(0, 16'($urandom), 2, -1, 9, -1, 1'b0, 1'b0, r);
    if (r) do_sweep(0, 16'($urandom), 2, -1, -1, -1, 1'b0, 1'b1, r);

    for (int k = 0; k < 24; k++) begin
      ii = int'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      if (ab > 0) md = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, ab - 1)) : -1;
      else if (ab < 0) md = int'($urandom_range(0, 14));
      else md = -1;
      do_sweep(ii, 16'($urandom), 2, ab, -1, md, 1'($urandom_range(0, 1)), 1'b0, r);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_exer2_2_sweep_ctrl.md
PROG_EXER2_2_SWEEP_CTRL -- requirements
Module: prog_exer2_2_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1: idle cycles between driving a vector and sampling f_in; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  cancels a sweep in progress.
REQ-006 expected  input  16  golden truth table; bit i = required F for x=i.
REQ-007 f_in  input  1  F output of the external 4-input function evaluator.
REQ-008 x_out  output  4  vector driven to the evaluator's x[3:0].
REQ-009 busy  output  1  high in SETTLE and SAMPLE states.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 aborted  output  1  one-cycle pulse on abort acceptance.
REQ-012 table_out  output  16  captured truth table; bit i = f_in sampled for x=i.
REQ-013 mismatch_cnt  output  5  count of positions where table_out differs from the latched expected value (0..16).
REQ-014 first_bad  output  4  lowest x index that mismatched; valid only when mismatch_cnt != 0.
REQ-015 mismatch  output  1  combinational (mismatch_cnt != 0).

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE with start=1: latch expected into exp_q, clear table_out, mismatch_cnt and first_bad, set x_out=0, load wait counter with SETTLE, go to SETTLE.
REQ-018 SETTLE: hold x_out; decrement the wait counter each cycle; when the counter is 0, go to SAMPLE (SETTLE=0 gives zero cycles in SETTLE, i.e. SAMPLE is entered directly from IDLE or SAMPLE).
REQ-019 SAMPLE (exactly one cycle): write f_in to table_out[x_out]; if f_in != exp_q[x_out], increment mismatch_cnt; if this is the first mismatch of the sweep, record first_bad=x_out.
REQ-020 SAMPLE with x_out=15: go to DONE; otherwise increment x_out and reload the wait counter.
REQ-021 DONE: assert done for one cycle, go to IDLE; results hold until the next accepted start.
REQ-022 Total latency from the start-accept edge to the done-high cycle SHALL be 16*(SETTLE+1)+1 cycles.
REQ-023 start while busy or in DONE SHALL be ignored, with no queueing.
REQ-024 abort while busy: next state IDLE, aborted pulses for one cycle, done not asserted, partial table_out and mismatch_cnt retained, x_out retained.
REQ-025 abort and start in the same IDLE cycle: start wins; abort in IDLE or DONE is ignored.
REQ-026 x_out SHALL NOT wrap; the sweep terminates at 15.
REQ-027 mismatch_cnt SHALL be 5 bits wide so that 16 mismatches are representable without overflow.
REQ-028 No combinational path from f_in to any output except through registered state.

Reset
REQ-029 rst_n low, asynchronously: state=IDLE, x_out=0, busy=0, done=0, aborted=0, table_out=0, mismatch_cnt=0, first_bad=0, exp_q=0, wait counter=0.
REQ-030 Reset mid-sweep SHALL discard all progress; no done or aborted pulse is generated.
REQ-031 After reset release, the first start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-032 Golden sweep, SETTLE=1, f_in from the reference evaluator (F = x3'x2 + x1x0 + x3x2' + x3x1'x0'), expected=0x9FF8 -> table_out=0x9FF8, mismatch_cnt=0, done high exactly 33 cycles after start accepted.
REQ-033 Same stimulus, expected=0x9FF0 -> table_out=0x9FF8, mismatch_cnt=1, first_bad=3, mismatch=1.
REQ-034 f_in tied 0, expected=0xFFFF, SETTLE=0 -> table_out=0x0000, mismatch_cnt=16, first_bad=0, done 17 cycles after start accepted.
REQ-035 abort asserted while x_out=5 -> aborted pulse for one cycle, no done, busy low the next cycle, table_out bits 4:0 retained; start asserted during the sweep (before the abort) is ignored.
REQ-036 rst_n pulsed low at x_out=9 -> all outputs 0 immediately; a new start afterwards completes a full sweep with correct results.
